// File: rtl/piezo_pkg.sv
// Shared definitions for the piezo melody sequencer and its song ROM.
package piezo_pkg;

  // Note indices; bit N of the tone stage's one-hot input selects note N.
  localparam int unsigned NOTE_C2 = 0;
  localparam int unsigned NOTE_D2 = 1;
  localparam int unsigned NOTE_E2 = 2;
  localparam int unsigned NOTE_F2 = 3;
  localparam int unsigned NOTE_G2 = 4;
  localparam int unsigned NOTE_A2 = 5;
  localparam int unsigned NOTE_B2 = 6;
  localparam int unsigned NOTE_C3 = 7;

  // Song entry layout: [7:4] dur, [3] rest, [2:0] idx.
  localparam int unsigned ENTRY_W  = 8;
  localparam int unsigned DUR_LSB  = 4;
  localparam int unsigned DUR_W    = 4;
  localparam int unsigned REST_BIT = 3;
  localparam int unsigned IDX_LSB  = 0;
  localparam int unsigned IDX_W    = 3;
  localparam int unsigned NOTE_W   = 8;
  localparam int unsigned ADDR_W   = 5;

  // An entry with dur = 0 terminates the song.
  localparam logic [ENTRY_W-1:0] END_MARKER = 8'h00;

  typedef struct packed {
    logic [DUR_W-1:0] dur;
    logic             rest;
    logic [IDX_W-1:0] idx;
  } entry_t;

  typedef enum logic [1:0] {
    StIdle,
    StNote,
    StGap
  } seq_state_e;

  function automatic entry_t mk_entry(input int unsigned dur, input logic rest,
                                      input int unsigned idx);
    entry_t e;
    e.dur  = DUR_W'(dur);
    e.rest = rest;
    e.idx  = IDX_W'(idx);
    return e;
  endfunction

  function automatic logic is_end(input entry_t e);
    return e.dur == '0;
  endfunction

  function automatic logic [NOTE_W-1:0] note_onehot(input entry_t e);
    return e.rest ? '0 : (NOTE_W'(1) << e.idx);
  endfunction

endpackage

// File: rtl/piezo_song_rom.sv
// Song ROM: 32 entries, asynchronous read. SONG_SEL picks a built-in song;
// 0 is the default scale, 1 is an empty song (end marker at address 0).
module piezo_song_rom
  import piezo_pkg::*;
#(
  parameter int unsigned SONG_SEL = 0
) (
  input  logic [ADDR_W-1:0] addr_i,
  output entry_t            entry_o
);

  // Constant table lookup; unlisted addresses read as the end marker.
  always_comb begin
    entry_o = entry_t'(END_MARKER);
    if (SONG_SEL == 0) begin
      case (addr_i)
        5'd0:    entry_o = mk_entry(1, 1'b0, NOTE_C2);
        5'd1:    entry_o = mk_entry(1, 1'b0, NOTE_D2);
        5'd2:    entry_o = mk_entry(1, 1'b0, NOTE_E2);
        5'd3:    entry_o = mk_entry(1, 1'b0, NOTE_F2);
        5'd4:    entry_o = mk_entry(1, 1'b0, NOTE_G2);
        5'd5:    entry_o = mk_entry(1, 1'b0, NOTE_A2);
        5'd6:    entry_o = mk_entry(1, 1'b0, NOTE_B2);
        5'd7:    entry_o = mk_entry(1, 1'b0, NOTE_C3);
        5'd8:    entry_o = mk_entry(2, 1'b1, NOTE_C2);
        default: entry_o = entry_t'(END_MARKER);
      endcase
    end
  end

endmodule

// File: rtl/piezo_melody_seq.sv
// Melody sequencer: walks the song ROM, driving one-hot notes and a sound
// enable for dur beats per entry, with an optional silent gap after each.
module piezo_melody_seq
  import piezo_pkg::*;
#(
  parameter int unsigned BEAT_CYC = 250_000,
  parameter int unsigned GAP_CYC  = 25_000,
  parameter bit          LOOP     = 1'b0,
  parameter int unsigned SONG_SEL = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  output logic [NOTE_W-1:0] note_oh,
  output logic              sound_en,
  output logic              playing,
  output logic              done
);

  localparam int unsigned BEAT_W = (BEAT_CYC > 1) ? $clog2(BEAT_CYC) : 1;
  localparam int unsigned GAP_W  = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEAT_CYC - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [DUR_W-1:0]  beats_left_q, beats_left_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic [NOTE_W-1:0] note_oh_q, note_oh_d;
  logic              sound_en_q, sound_en_d;
  logic              playing_q, playing_d;
  logic              done_q, done_d;

  logic [ADDR_W-1:0] nxt_addr;
  entry_t            head_entry, nxt_entry, load_entry;
  logic              advance, load;

  assign nxt_addr = addr_q + 1'b1;

  // Entry 0 is needed both to start and to wrap when looping, so it gets its
  // own read port alongside the look-ahead read of the following entry.
  piezo_song_rom #(
    .SONG_SEL(SONG_SEL)
  ) u_rom_head (
    .addr_i (ADDR_W'(0)),
    .entry_o(head_entry)
  );

  piezo_song_rom #(
    .SONG_SEL(SONG_SEL)
  ) u_rom_nxt (
    .addr_i (nxt_addr),
    .entry_o(nxt_entry)
  );

  // Next-state, counters and registered outputs; stop overrides everything.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    beat_cnt_d   = beat_cnt_q;
    beats_left_d = beats_left_q;
    gap_cnt_d    = gap_cnt_q;
    note_oh_d    = note_oh_q;
    sound_en_d   = sound_en_q;
    playing_d    = playing_q;
    done_d       = 1'b0;
    advance      = 1'b0;
    load         = 1'b0;
    load_entry   = head_entry;

    case (state_q)
      StIdle: begin
        if (start) begin
          if (is_end(head_entry)) begin
            done_d = 1'b1;
          end else begin
            load   = 1'b1;
            addr_d = '0;
          end
        end
      end
      StNote: begin
        if (beat_cnt_q == BEAT_LAST) begin
          beat_cnt_d = '0;
          if (beats_left_q <= 4'd1) begin
            if (GAP_CYC > 0) begin
              state_d    = StGap;
              gap_cnt_d  = '0;
              note_oh_d  = '0;
              sound_en_d = 1'b0;
            end else begin
              advance = 1'b1;
            end
          end else begin
            beats_left_d = beats_left_q - 1'b1;
          end
        end else begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
      end
      StGap: begin
        if (gap_cnt_q == GAP_LAST) begin
          advance = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // End of an entry: move on, wrap, or finish the song.
    if (advance) begin
      if (is_end(nxt_entry) || (addr_q == '1)) begin
        if (LOOP && !is_end(head_entry)) begin
          load   = 1'b1;
          addr_d = '0;
        end else begin
          state_d    = StIdle;
          addr_d     = '0;
          beat_cnt_d = '0;
          gap_cnt_d  = '0;
          note_oh_d  = '0;
          sound_en_d = 1'b0;
          playing_d  = 1'b0;
          done_d     = 1'b1;
        end
      end else begin
        load       = 1'b1;
        load_entry = nxt_entry;
        addr_d     = nxt_addr;
      end
    end

    if (load) begin
      state_d      = StNote;
      beat_cnt_d   = '0;
      beats_left_d = load_entry.dur;
      gap_cnt_d    = '0;
      note_oh_d    = note_onehot(load_entry);
      sound_en_d   = ~load_entry.rest;
      playing_d    = 1'b1;
    end

    if (stop) begin
      state_d      = StIdle;
      addr_d       = '0;
      beat_cnt_d   = '0;
      beats_left_d = '0;
      gap_cnt_d    = '0;
      note_oh_d    = '0;
      sound_en_d   = 1'b0;
      playing_d    = 1'b0;
      done_d       = 1'b0;
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      beat_cnt_q   <= '0;
      beats_left_q <= '0;
      gap_cnt_q    <= '0;
      note_oh_q    <= '0;
      sound_en_q   <= 1'b0;
      playing_q    <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      beat_cnt_q   <= beat_cnt_d;
      beats_left_q <= beats_left_d;
      gap_cnt_q    <= gap_cnt_d;
      note_oh_q    <= note_oh_d;
      sound_en_q   <= sound_en_d;
      playing_q    <= playing_d;
      done_q       <= done_d;
    end
  end

  assign note_oh  = note_oh_q;
  assign sound_en = sound_en_q;
  assign playing  = playing_q;
  assign done     = done_q;

endmodule

// File: tb/tb_piezo_melody_seq.sv
// Scoreboard bench: five sequencer configurations share start/stop. On each
// accepted start the song-level model pushes the full per-cycle output trace;
// a monitor pops one expected tuple per cycle per instance and compares.
module tb_piezo_melody_seq;

  typedef struct packed {
    logic [7:0] note;
    logic       snd;
    logic       ply;
    logic       dn;
  } obs_t;

  localparam int N = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic stop = 1'b0;

  logic [7:0] note_w [N];
  logic       snd_w  [N];
  logic       ply_w  [N];
  logic       dn_w   [N];

  // Per-instance configuration: beat cycles, gap cycles, loop, song.
  int beat_p [N] = '{4, 4, 4, 4, 1};
  int gap_p  [N] = '{2, 2, 0, 2, 1};
  bit loop_p [N] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  int song_p [N] = '{0, 0, 0, 1, 0};

  logic [7:0] song_m [2][32];
  obs_t       exp_q  [N][$];
  obs_t       cur_exp [N];
  bit         loop_on [N];
  bit         mon_en = 1'b0;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;

  always #5 clk = ~clk;

  piezo_melody_seq #(.BEAT_CYC(4), .GAP_CYC(2), .LOOP(1'b0), .SONG_SEL(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .note_oh(note_w[0]), .sound_en(snd_w[0]), .playing(ply_w[0]), .done(dn_w[0]));
  piezo_melody_seq #(.BEAT_CYC(4), .GAP_CYC(2), .LOOP(1'b1), .SONG_SEL(0)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .note_oh(note_w[1]), .sound_en(snd_w[1]), .playing(ply_w[1]), .done(dn_w[1]));
  piezo_melody_seq #(.BEAT_CYC(4), .GAP_CYC(0), .LOOP(1'b0), .SONG_SEL(0)) u_dut2 (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .note_oh(note_w[2]), .sound_en(snd_w[2]), .playing(ply_w[2]), .done(dn_w[2]));
  piezo_melody_seq #(.BEAT_CYC(4), .GAP_CYC(2), .LOOP(1'b0), .SONG_SEL(1)) u_dut3 (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .note_oh(note_w[3]), .sound_en(snd_w[3]), .playing(ply_w[3]), .done(dn_w[3]));
  piezo_melody_seq #(.BEAT_CYC(1), .GAP_CYC(1), .LOOP(1'b0), .SONG_SEL(0)) u_dut4 (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .note_oh(note_w[4]), .sound_en(snd_w[4]), .playing(ply_w[4]), .done(dn_w[4]));

  function automatic obs_t mk(input logic [7:0] n, input logic s, input logic p,
                              input logic d);
    return {n, s, p, d};
  endfunction

  // One playthrough of song s for instance k, cycle by cycle from the first note.
  task automatic push_pass(input int k);
    int         s;
    int         len;
    logic [7:0] e;
    logic [7:0] n;
    s = song_p[k];
    e = song_m[s][0];
    if (e[7:4] == 4'd0) begin
      exp_q[k].push_back(mk(8'h00, 1'b0, 1'b0, 1'b1));
      return;
    end
    for (int a = 0; a < 32; a++) begin
      e = song_m[s][a];
      if (e[7:4] == 4'd0) break;
      n = e[3] ? 8'h00 : (8'h01 << e[2:0]);
      len = int'(e[7:4]) * beat_p[k];
      for (int c = 0; c < len; c++) exp_q[k].push_back(mk(n, ~e[3], 1'b1, 1'b0));
      for (int g = 0; g < gap_p[k]; g++) exp_q[k].push_back(mk(8'h00, 1'b0, 1'b1, 1'b0));
    end
    if (!loop_p[k]) exp_q[k].push_back(mk(8'h00, 1'b0, 1'b0, 1'b1));
  endtask

  // Model reaction to the inputs sampled at this clock edge.
  task automatic model_edge();
    logic [7:0] head;
    for (int k = 0; k < N; k++) begin
      head = song_m[song_p[k]][0];
      if (stop) begin
        exp_q[k].delete();
        loop_on[k] = 1'b0;
      end else if (start && !cur_exp[k].ply) begin
        push_pass(k);
        loop_on[k] = loop_p[k] && (head[7:4] != 4'd0);
      end
    end
  endtask

  task automatic cyc_drive(input bit s, input bit p);
    @(negedge clk);
    #2;
    start = s;
    stop  = p;
    @(posedge clk);
    model_edge();
  endtask

  // Monitor: one expected tuple per instance per cycle; empty queue means idle.
  initial begin
    obs_t got;
    obs_t ex;
    wait (mon_en);
    forever begin
      @(negedge clk);
      cyc++;
      for (int k = 0; k < N; k++) begin
        if (exp_q[k].size() > 0) ex = exp_q[k].pop_front();
        else ex = '0;
        if (exp_q[k].size() == 0 && loop_on[k]) push_pass(k);
        cur_exp[k] = ex;
        got = {note_w[k], snd_w[k], ply_w[k], dn_w[k]};
        checks++;
        if (got !== ex) begin
          errors++;
          $display("FAIL out_inst%0d cyc%0d got note=%h snd=%b ply=%b done=%b required note=%h snd=%b ply=%b done=%b",
                   k, cyc, got.note, got.snd, got.ply, got.dn, ex.note, ex.snd, ex.ply, ex.dn);
        end
      end
    end
  end

  initial begin
    obs_t got;
    for (int a = 0; a < 32; a++) begin
      song_m[0][a] = 8'h00;
      song_m[1][a] = 8'h00;
    end
    for (int i = 0; i < 8; i++) song_m[0][i] = {4'd1, 1'b0, 3'(i)};
    song_m[0][8] = {4'd2, 1'b1, 3'd0};
    for (int k = 0; k < N; k++) begin
      cur_exp[k] = '0;
      loop_on[k] = 1'b0;
    end

    #3 rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    mon_en = 1'b1;

    // Full song, with a redundant start at t+3.
    repeat (2) cyc_drive(1'b0, 1'b0);
    cyc_drive(1'b1, 1'b0);
    repeat (2) cyc_drive(1'b0, 1'b0);
    cyc_drive(1'b1, 1'b0);
    repeat (66) cyc_drive(1'b0, 1'b0);

    // Stop at t+8, start+stop together in idle, then replay.
    cyc_drive(1'b1, 1'b0);
    repeat (7) cyc_drive(1'b0, 1'b0);
    cyc_drive(1'b0, 1'b1);
    repeat (3) cyc_drive(1'b0, 1'b0);
    cyc_drive(1'b1, 1'b1);
    repeat (3) cyc_drive(1'b0, 1'b0);
    cyc_drive(1'b1, 1'b0);
    repeat (19) cyc_drive(1'b0, 1'b0);

    // Asynchronous reset in the middle of cycle t+20.
    #3 rst = 1'b0;
    #1;
    for (int k = 0; k < N; k++) begin
      got = {note_w[k], snd_w[k], ply_w[k], dn_w[k]};
      checks++;
      if (got !== '0) begin
        errors++;
        $display("FAIL async_rst_inst%0d got %h required 000", k, got);
      end
      exp_q[k].delete();
      loop_on[k] = 1'b0;
      cur_exp[k] = '0;
    end
    @(negedge clk);
    #2 rst = 1'b1;
    repeat (4) cyc_drive(1'b0, 1'b0);

    // Randomised start/stop traffic.
    repeat (3000) cyc_drive($urandom_range(0, 29) == 0, $urandom_range(0, 199) == 0);
    repeat (80) cyc_drive(1'b0, 1'b0);

    @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/piezo_melody_seq.md
# piezo_melody_seq

Upstream sequencer for the piezo tone stage. It plays a fixed melody from an internal ROM and drives the tone stage's one-hot note input, one note at a time, for a programmed duration. It also provides a sound-enable flag so the top level can gate the speaker during rests and inter-note gaps. The tone stage holds its last pitch when its note input is all-zero, so silencing is done only through `sound_en`. The design runs on the same 1 MHz `clk` as the tone stage.

## Interface
Parameters:
- `BEAT_CYC`, default 250_000: clk cycles per beat (250 ms at 1 MHz); must be ≥ 1.
- `GAP_CYC`, default 25_000: silent cycles inserted after every entry; 0 means no gap.
- `LOOP`, default 0: 1 restarts at address 0 instead of finishing.

Ports:
- `clk`, in, 1: system clock.
- `rst`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: single-cycle request to begin playback; sampled only in IDLE.
- `stop`, in, 1: abort playback; takes effect in any state.
- `note_oh`, out, 8: one-hot note to the tone stage (bit0 = C2 … bit7 = C3); 0 when not sounding.
- `sound_en`, out, 1: high only while a non-rest note is sounding.
- `playing`, out, 1: high in NOTE and GAP.
- `done`, out, 1: one-cycle pulse on natural song completion.

## Operation
- ROM: 32 entries × 8 bits, addressed by a 5-bit `addr`, with asynchronous read.
- Entry fields:
  - [7:4] `dur`: length in beats, 1–15.
  - [3] `rest`.
  - [2:0] `idx`: note index.
  - `dur` = 0 is the end marker.
- `note_oh` = 1<<idx when not rest. It is 0 for a rest.
- Default song: C2 C2… specifically idx 0,1,2,3,4,5,6,7, each dur 1 and not rest. Then a rest with dur 2. Then an end marker at address 9.
- States:
  - IDLE: all outputs 0.
    - `start` & !`stop` → if entry[0] is the end marker, pulse `done` and stay in IDLE; else go to NOTE with addr=0.
  - NOTE: outputs drive the current entry.
    - Beat counter counts 0..BEAT_CYC-1; `beats_left` (4 bits) is loaded with `dur` and decrements on each beat wrap.
    - When the last beat ends → GAP if GAP_CYC>0, else go directly to ADVANCE.
  - GAP: `note_oh`=0 and `sound_en`=0, for GAP_CYC cycles.
  - ADVANCE: combinational decision, not a state.
    - Set addr+1.
    - If the next entry is an end marker, or addr was 31: with LOOP=0, go to IDLE and pulse `done`; with LOOP=1, go to NOTE at addr 0 with no `done`.
    - Otherwise go to NOTE.
- `stop`: IDLE on the next edge, all outputs 0, no `done`. `stop` wins over a simultaneous `start`.
- `start` while `playing` is ignored.
- Counter widths:
  - beat counter: $clog2(BEAT_CYC) bits, minimum 1.
  - gap counter: $clog2(GAP_CYC+1) bits.
  - No overflow: each counter compares against its limit minus 1 and clears.

## Timing
- All outputs are registered.
- Reset values: `note_oh`=0, `sound_en`=0, `playing`=0, `done`=0, state=IDLE, addr=0, counters=0.
- `start` sampled at edge t:
  - first note appears at t+1;
  - entry k occupies dur·BEAT_CYC cycles of NOTE followed by GAP_CYC cycles of GAP;
  - the next entry's note appears on the cycle immediately after its predecessor's gap.
- `done` is high in the first cycle after the final gap (or final NOTE if GAP_CYC=0), and `playing` is 0 in that same cycle.
- End marker at addr 0: `done` at t+1 and `playing` never rises.
- Asynchronous reset mid-song forces IDLE immediately. Playback resumes only on a new `start`.

## Structure
- Package `piezo_pkg`:
  - note-index localparams NOTE_C2..NOTE_C3 (0–7);
  - entry field positions/widths;
  - END_MARKER (dur=0).
  - The tone stage shares the one-hot mapping.
- Sub-module `piezo_song_rom`: 5-bit address in, 8-bit entry out, contents as a case constant. This lets songs be swapped without touching the FSM.

## Test plan
Bench parameters: BEAT_CYC=4, GAP_CYC=2 (default song unless noted).
- Reset, then `start` at t → `note_oh` is 8'h01 for t+1..t+4, 0 for t+5..t+6, and 8'h02 for t+7..t+10; `sound_en` tracks these windows; `playing` is 1 from t+1.
- Full song → entry 7 gives 8'h80 for t+43..t+46. The rest gives `note_oh`=0 and `sound_en`=0 for t+49..t+58. `done`=1 only at t+59, with `playing`=0 at t+59.
- `stop` at t+8 → at t+9 all outputs are 0; no `done`; a second `start` replays from 8'h01.
- `start` pulsed at t+3 during playback → timing is identical to the first scenario; `start` and `stop` in the same IDLE cycle → stays in IDLE.
- LOOP=1 → after the rest, 8'h01 reappears at t+59 with no `done` pulse. GAP_CYC=0 → 8'h02 starts at t+5.
- ROM entry 0 set to the end marker → `done` at t+1 only. Async `rst` low at t+20 → outputs are 0 within the same cycle.
